kmeans_sequencer: RTL and testbench

- Per-frame controller wrapped around the k_means clustering engine. It owns the engine's reset and its new_frame strobe, and chooses the seed centroids for each run.
- Seeds are either the previous result (temporal tracking) or a default spread across the frame. A watchdog bounds compute time.
- Published centroids feed the juggling-pattern logic downstream.
- Engine runs on alternating frame windows: store during frame F, compute during frame F+1.

---
 rtl/kmeans_sequencer.sv | 170 +++++++++++++++++
 tb/tb_kmeans_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kmeans_sequencer.sv
// kmeans_sequencer: per-frame controller for the k_means clustering engine.
// Owns the engine's reset and new_frame strobe, picks seed centroids (previous
// result or a default spread across the frame) and bounds compute time with a
// watchdog. The engine stores during one frame window and computes during the
// next.
// Optional build macro KMEANS_SEQ_STATS_EN adds frames_done_out (16b, wrapping
// publish count) and last_latency_out (22b, saturating COMPUTE cycles at publish).
module kmeans_sequencer #(
    parameter int unsigned WIDTH          = 320,
    parameter int unsigned HEIGHT         = 180,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        new_frame_in,
    input  logic [2:0]  num_balls_in,
    input  logic        km_valid_in,
    input  logic [62:0] km_centroids_x_in,
    input  logic [55:0] km_centroids_y_in,
    output logic        km_rst_out,
    output logic        km_new_frame_out,
    output logic [62:0] km_seed_x_out,
    output logic [55:0] km_seed_y_out,
    output logic [2:0]  km_num_balls_out,
    output logic [62:0] centroids_x_out,
    output logic [55:0] centroids_y_out,
    output logic        centroids_valid_out,
    output logic        timeout_out,
    output logic        busy_out
`ifdef KMEANS_SEQ_STATS_EN
    ,
    output logic [15:0] frames_done_out,
    output logic [21:0] last_latency_out
`endif
);

    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        STORE,
        COMPUTE
    } state_t;

    state_t          state;
    logic            use_default;
    logic [WD_W-1:0] wd_count;
    logic [2:0]      num_balls;
    logic [62:0]     seed_x;
    logic [55:0]     seed_y;

    // Default seed table, one packed row per requested count. Row 0 mirrors
    // row 1 so a request of zero balls indexes straight into the N=1 spread.
    logic [62:0] dflt_x [8];
    logic [55:0] dflt_y [8];

    for (genvar n = 0; n < 8; n++) begin : g_dflt_n
        localparam int unsigned NN = (n == 0) ? 1 : n;
        for (genvar i = 0; i < 7; i++) begin : g_dflt_i
            localparam int unsigned XV = (i < NN) ? ((2 * i + 1) * WIDTH) / (2 * NN) : 0;
            localparam int unsigned YV = (i < NN) ? HEIGHT / 2 : 0;
            assign dflt_x[n][i*9 +: 9] = 9'(XV);
            assign dflt_y[n][i*8 +: 8] = 8'(YV);
        end
    end

    logic [2:0]  n_eff;
    logic        pick_default;
    logic [62:0] arm_seed_x;
    logic [55:0] arm_seed_y;
    logic        publish;

    // Seed selection evaluated during ARM from the live ball-count request.
    always_comb begin
        n_eff        = (num_balls_in == 3'd0) ? 3'd1 : num_balls_in;
        pick_default = use_default || (n_eff != num_balls);
        arm_seed_x   = pick_default ? dflt_x[num_balls_in] : centroids_x_out;
        arm_seed_y   = pick_default ? dflt_y[num_balls_in] : centroids_y_out;
        publish      = (state == COMPUTE) && km_valid_in;
    end

    // Seeds and ball count are presented in the ARM cycle itself and then held
    // from the registered copies until the next ARM.
    assign km_seed_x_out    = (state == ARM) ? arm_seed_x : seed_x;
    assign km_seed_y_out    = (state == ARM) ? arm_seed_y : seed_y;
    assign km_num_balls_out = (state == ARM) ? n_eff : num_balls;
    assign km_rst_out       = rst_in || (state == ARM);
    assign busy_out         = (state != IDLE);

    // Frame sequencing FSM with registered pulses, seeds, results and watchdog.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state               <= IDLE;
            use_default         <= 1'b1;
            wd_count            <= '0;
            num_balls           <= '0;
            seed_x              <= '0;
            seed_y              <= '0;
            centroids_x_out     <= '0;
            centroids_y_out     <= '0;
            km_new_frame_out    <= 1'b0;
            centroids_valid_out <= 1'b0;
            timeout_out         <= 1'b0;
        end else begin
            km_new_frame_out    <= 1'b0;
            centroids_valid_out <= 1'b0;
            timeout_out         <= 1'b0;
            case (state)
                IDLE: begin
                    if (new_frame_in) state <= ARM;
                end
                ARM: begin
                    num_balls   <= n_eff;
                    seed_x      <= arm_seed_x;
                    seed_y      <= arm_seed_y;
                    use_default <= 1'b0;
                    state       <= STORE;
                end
                STORE: begin
                    if (new_frame_in) begin
                        km_new_frame_out <= 1'b1;
                        wd_count         <= '0;
                        state            <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    if (km_valid_in) begin
                        centroids_x_out     <= km_centroids_x_in;
                        centroids_y_out     <= km_centroids_y_in;
                        centroids_valid_out <= 1'b1;
                        state               <= new_frame_in ? ARM : IDLE;
                    end else if (wd_count == WD_LAST) begin
                        timeout_out <= 1'b1;
                        use_default <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wd_count <= wd_count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KMEANS_SEQ_STATS_EN
    logic [21:0] lat_count;

    // Publish counter and saturating COMPUTE-latency capture.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            lat_count        <= '0;
            frames_done_out  <= '0;
            last_latency_out <= '0;
        end else begin
            if (state == STORE && new_frame_in) begin
                lat_count <= '0;
            end else if (state == COMPUTE && lat_count != '1) begin
                lat_count <= lat_count + 1'b1;
            end
            if (publish) begin
                frames_done_out  <= frames_done_out + 1'b1;
                last_latency_out <= (lat_count == '1) ? '1 : lat_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_kmeans_sequencer.sv
// Self-checking bench for kmeans_sequencer: a short table of cycle vectors for
// reset and the first frame, then directed sequences for compute, seed reuse,
// timeout, terminal-count race, simultaneous frame/valid and mid-run reset.
module tb_kmeans_sequencer;

    localparam int unsigned TO = 600;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_frame;
    logic [2:0]  num_balls;
    logic        km_valid;
    logic [62:0] km_cx;
    logic [55:0] km_cy;
    logic        km_rst;
    logic        km_nf;
    logic [62:0] seed_x;
    logic [55:0] seed_y;
    logic [2:0]  km_nb;
    logic [62:0] cx;
    logic [55:0] cy;
    logic        cv;
    logic        to;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    kmeans_sequencer #(
        .WIDTH(320),
        .HEIGHT(180),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .new_frame_in(new_frame),
        .num_balls_in(num_balls),
        .km_valid_in(km_valid),
        .km_centroids_x_in(km_cx),
        .km_centroids_y_in(km_cy),
        .km_rst_out(km_rst),
        .km_new_frame_out(km_nf),
        .km_seed_x_out(seed_x),
        .km_seed_y_out(seed_y),
        .km_num_balls_out(km_nb),
        .centroids_x_out(cx),
        .centroids_y_out(cy),
        .centroids_valid_out(cv),
        .timeout_out(to),
        .busy_out(busy)
    );

    function automatic logic [62:0] px(input int unsigned a0, a1, a2, a3, a4, a5, a6);
        return {9'(a6), 9'(a5), 9'(a4), 9'(a3), 9'(a2), 9'(a1), 9'(a0)};
    endfunction

    function automatic logic [55:0] py(input int unsigned a0, a1, a2, a3, a4, a5, a6);
        return {8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string      name;
        logic       rst;
        logic       nf;
        logic [2:0] nb;
        logic       e_rst;
        logic       e_nf;
        logic       e_busy;
        logic       e_cv;
        logic       e_to;
        logic [8:0] e_seed0;
        logic [2:0] e_nb;
    } vec_t;

    vec_t vecs [7];

    logic [62:0] kx_a, kx_b, kx_c, kx_d;
    logic [55:0] ky_a, ky_b, ky_c, ky_d;
    logic [62:0] dx3, dx4, dx1;
    logic [55:0] dy3, dy4, dy1;

    initial begin
        int n;
        logic seen;
        logic broke;

        kx_a = px(100, 150, 250, 0, 0, 0, 0);  ky_a = py(80, 81, 82, 0, 0, 0, 0);
        kx_b = px(101, 151, 251, 0, 0, 0, 0);  ky_b = py(70, 71, 72, 0, 0, 0, 0);
        kx_c = px(11, 22, 33, 44, 0, 0, 0);    ky_c = py(12, 23, 34, 45, 0, 0, 0);
        kx_d = px(5, 6, 7, 8, 9, 10, 11);      ky_d = py(1, 2, 3, 4, 5, 6, 7);
        dx3  = px(53, 160, 266, 0, 0, 0, 0);   dy3  = py(90, 90, 90, 0, 0, 0, 0);
        dx4  = px(40, 120, 200, 280, 0, 0, 0); dy4  = py(90, 90, 90, 90, 0, 0, 0);
        dx1  = px(160, 0, 0, 0, 0, 0, 0);      dy1  = py(90, 0, 0, 0, 0, 0, 0);

        //          name           rst  nf   nb    rst  nf   busy cv   to   seed0 nb
        vecs[0] = '{"reset",       1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0,  3'd0};
        vecs[1] = '{"idle",        1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0,  3'd0};
        vecs[2] = '{"arm",         1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'd53, 3'd3};
        vecs[3] = '{"arm_nf_ign",  1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'd53, 3'd3};
        vecs[4] = '{"store_nf",    1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'd53, 3'd3};
        vecs[5] = '{"compute_1",   1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'd53, 3'd3};
        vecs[6] = '{"compute_2",   1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'd53, 3'd3};

        rst = 1'b1; new_frame = 1'b0; num_balls = 3'd3; km_valid = 1'b0;
        km_cx = '0; km_cy = '0;

        for (int v = 0; v < 7; v++) begin
            rst       = vecs[v].rst;
            new_frame = vecs[v].nf;
            num_balls = vecs[v].nb;
            tick();
            chk({vecs[v].name, ".km_rst"},   64'(km_rst),        64'(vecs[v].e_rst));
            chk({vecs[v].name, ".km_nf"},    64'(km_nf),         64'(vecs[v].e_nf));
            chk({vecs[v].name, ".busy"},     64'(busy),          64'(vecs[v].e_busy));
            chk({vecs[v].name, ".cv"},       64'(cv),            64'(vecs[v].e_cv));
            chk({vecs[v].name, ".timeout"},  64'(to),            64'(vecs[v].e_to));
            chk({vecs[v].name, ".seed_x0"},  64'(seed_x[8:0]),   64'(vecs[v].e_seed0));
            chk({vecs[v].name, ".km_nb"},    64'(km_nb),         64'(vecs[v].e_nb));
            if (v == 0) begin
                chk("reset.cx", 64'(cx), 64'd0);
                chk("reset.seed_y", 64'(seed_y), 64'd0);
            end
        end
        new_frame = 1'b0;
        chk("default3.seed_x", 64'(seed_x), 64'(dx3));
        chk("default3.seed_y", 64'(seed_y), 64'(dy3));

        // Finish the first compute: valid arrives on COMPUTE edge 500.
        broke = 1'b0;
        repeat (497) begin
            tick();
            if (!busy || cv || to || km_nf) broke = 1'b1;
        end
        chk("compute_wait_stable", 64'(broke), 64'd0);
        km_valid = 1'b1; km_cx = kx_a; km_cy = ky_a;
        tick();
        km_valid = 1'b0; km_cx = '0; km_cy = '0;
        chk("publish_a.cv", 64'(cv), 64'd1);
        chk("publish_a.cx", 64'(cx), 64'(kx_a));
        chk("publish_a.cy", 64'(cy), 64'(ky_a));
        chk("publish_a.busy", 64'(busy), 64'd0);
        tick();
        chk("publish_a.cv_pulse", 64'(cv), 64'd0);
        chk("publish_a.cx_hold", 64'(cx), 64'(kx_a));

        // Same N: ARM reuses the published centroids.
        new_frame = 1'b1; tick();
        chk("reuse.km_rst", 64'(km_rst), 64'd1);
        chk("reuse.seed_x", 64'(seed_x), 64'(kx_a));
        chk("reuse.seed_y", 64'(seed_y), 64'(ky_a));
        new_frame = 1'b0; tick();
        new_frame = 1'b1; tick();
        new_frame = 1'b0;
        km_valid = 1'b1; km_cx = kx_b; km_cy = ky_b; tick();
        km_valid = 1'b0;
        chk("publish_b.cx", 64'(cx), 64'(kx_b));

        // N changes to 4: defaults again.
        num_balls = 3'd4; new_frame = 1'b1; tick();
        chk("n4.seed_x", 64'(seed_x), 64'(dx4));
        chk("n4.seed_y", 64'(seed_y), 64'(dy4));
        chk("n4.km_nb", 64'(km_nb), 64'd4);
        new_frame = 1'b0; tick();
        chk("n4.seed_hold", 64'(seed_x), 64'(dx4));

        // Watchdog expiry, with a skipped frame pulse mid-compute.
        new_frame = 1'b1; tick();
        seen = 1'b0; broke = 1'b0; n = 0;
        for (int k = 1; k <= 700 && !seen; k++) begin
            new_frame = (k == 100);
            tick();
            if (to) begin
                seen = 1'b1;
                n = k;
                chk("timeout.busy", 64'(busy), 64'd0);
                chk("timeout.cv", 64'(cv), 64'd0);
            end else if (!busy || km_rst) begin
                broke = 1'b1;
            end
        end
        new_frame = 1'b0;
        chk("timeout.cycle", 64'(n), 64'(TO));
        chk("timeout.no_early_exit", 64'(broke), 64'd0);
        chk("timeout.cx_kept", 64'(cx), 64'(kx_b));
        tick();
        chk("timeout.pulse", 64'(to), 64'd0);

        // After timeout, same N still takes defaults.
        new_frame = 1'b1; tick();
        chk("post_to.seed_x", 64'(seed_x), 64'(dx4));
        new_frame = 1'b0; tick();

        // Valid on the terminal watchdog count wins.
        new_frame = 1'b1; tick();
        new_frame = 1'b0;
        broke = 1'b0;
        for (int k = 1; k < int'(TO); k++) begin
            tick();
            if (!busy || cv || to) broke = 1'b1;
        end
        chk("terminal.stable", 64'(broke), 64'd0);
        km_valid = 1'b1; km_cx = kx_c; km_cy = ky_c; tick();
        km_valid = 1'b0;
        chk("terminal.cv", 64'(cv), 64'd1);
        chk("terminal.no_timeout", 64'(to), 64'd0);
        chk("terminal.cx", 64'(cx), 64'(kx_c));
        tick();
        chk("terminal.no_timeout_late", 64'(to), 64'd0);

        // Reuse of C, then new_frame coincident with valid goes straight to ARM.
        new_frame = 1'b1; tick();
        chk("reuse_c.seed_x", 64'(seed_x), 64'(kx_c));
        chk("reuse_c.seed_y", 64'(seed_y), 64'(ky_c));
        new_frame = 1'b0; tick();
        new_frame = 1'b1; tick();
        new_frame = 1'b0; tick(); tick();
        new_frame = 1'b1; km_valid = 1'b1; km_cx = kx_d; km_cy = ky_d; tick();
        new_frame = 1'b0; km_valid = 1'b0;
        chk("simul.cv", 64'(cv), 64'd1);
        chk("simul.km_rst", 64'(km_rst), 64'd1);
        chk("simul.busy", 64'(busy), 64'd1);
        chk("simul.cx", 64'(cx), 64'(kx_d));
        chk("simul.seed_x", 64'(seed_x), 64'(kx_d));
        tick();
        chk("simul.store_rst", 64'(km_rst), 64'd0);
        chk("simul.seed_hold", 64'(seed_y), 64'(ky_d));

        // Reset in COMPUTE clears everything; a late valid is ignored.
        new_frame = 1'b1; tick();
        new_frame = 1'b0; tick();
        rst = 1'b1; tick();
        chk("midrst.km_rst", 64'(km_rst), 64'd1);
        chk("midrst.busy", 64'(busy), 64'd0);
        chk("midrst.cx", 64'(cx), 64'd0);
        chk("midrst.cy", 64'(cy), 64'd0);
        chk("midrst.seed_x", 64'(seed_x), 64'd0);
        chk("midrst.km_nb", 64'(km_nb), 64'd0);
        rst = 1'b0; tick();
        km_valid = 1'b1; km_cx = kx_a; km_cy = ky_a; tick();
        km_valid = 1'b0;
        chk("late_valid.cv", 64'(cv), 64'd0);
        chk("late_valid.cx", 64'(cx), 64'd0);
        chk("late_valid.busy", 64'(busy), 64'd0);

        // N=0 is treated as one ball.
        num_balls = 3'd0; new_frame = 1'b1; tick();
        new_frame = 1'b0;
        chk("n0.seed_x", 64'(seed_x), 64'(dx1));
        chk("n0.seed_y", 64'(seed_y), 64'(dy1));
        chk("n0.km_nb", 64'(km_nb), 64'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
